// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Contents: debounce_state_t (per-channel FSM states) and cnt_width(),
// which sizes the settle counter so it can hold 0..STABLE_CYCLES.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } debounce_state_t;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional 2-flop synchronizer, STABLE/SETTLING FSM and settle counter.
// Latency: a steady new level appears on o_Data STABLE_CYCLES sampling edges after it is
// first sampled (+2 edges when DEBOUNCE_SYNC_EN is defined). No backpressure: one sample per clock.
//
// Ports:
//   i_Clk      : clock, rising edge
//   i_Rst      : asynchronous active-high reset
//   i_Data     : raw key level (may be asynchronous when DEBOUNCE_SYNC_EN is defined)
//   o_Data     : debounced level, registered
//   o_Settling : high while the FSM is in ST_SETTLING (decoded from a state register)
// Build option: DEBOUNCE_SYNC_EN adds the input synchronizer.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Data,
  output logic o_Data,
  output logic o_Settling
);

  localparam int             CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic            w_sample;
  logic            w_differs;
  debounce_state_t r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_out, w_out_nxt;

`ifdef DEBOUNCE_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= i_Data;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  // Input is already synchronous to i_Clk in this build.
  assign w_sample = i_Data;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_out   <= RESET_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // The comparison always uses the current sample, so a level that returns
  // on the would-be commit edge cancels the flip.
  assign w_differs = (w_sample != r_out);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      ST_STABLE: begin
        if (!w_differs) begin
          w_cnt_nxt = '0;
        end else if (STABLE_CYCLES == 1) begin
          // A single differing sample is enough: commit without settling.
          w_out_nxt = ~r_out;
        end else begin
          w_state_nxt = ST_SETTLING;
          w_cnt_nxt   = CW'(1);
        end
      end
      ST_SETTLING: begin
        if (!w_differs) begin
          // Bounce back to the committed level: discard the pending change.
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_out_nxt   = ~r_out;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_Data     = r_out;
  assign o_Settling = (r_state == ST_SETTLING);

endmodule

// File: rtl/debounce.sv
// Multi-channel key debouncer: WIDTH independent channels turning bouncy levels into clean ones.
// Latency: STABLE_CYCLES sampling edges from first steady sample to o_Data (+2 with DEBOUNCE_SYNC_EN);
// o_Busy lags channel state by one cycle. No backpressure: every channel samples every clock.
//
// Ports:
//   i_Clk  : clock, rising edge
//   i_Rst  : asynchronous active-high reset
//   i_Data : raw key levels, WIDTH bits
//   o_Data : debounced levels, WIDTH bits, registered
//   o_Busy : registered OR of all channels currently settling
// Build option: DEBOUNCE_SYNC_EN adds a 2-flop synchronizer per channel.
module debounce
  import debounce_pkg::*;
#(
  parameter int   WIDTH         = 8,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Busy
);

  logic [WIDTH-1:0] w_settling;
  logic             r_busy;

  for (genvar n = 0; n < WIDTH; n++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE)
    ) u_chan (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Data     (i_Data[n]),
      .o_Data     (o_Data[n]),
      .o_Settling (w_settling[n])
    );
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_settling;
    end
  end

  assign o_Busy = r_busy;

endmodule
